// File: rtl/perf_pkg.sv
// Shared constants and types for the performance-counter block.
package perf_pkg;

    localparam int unsigned CNT_W_DEF  = 19;
    localparam int unsigned FRAC_W_DEF = 8;

    localparam logic [CNT_W_DEF-1:0] SAT_MAX = {CNT_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/perf_counters_if.sv
// Control/event inputs and counter/result outputs of perf_counters.
interface perf_counters_if #(
    parameter int unsigned CNT_W = perf_pkg::CNT_W_DEF
);
    logic             clear_i;
    logic             start_i;
    logic             halt_i;
    logic             stall_i;
    logic             arith_i;
    logic             mem_i;
    logic             retire_i;
    logic [CNT_W-1:0] stall_count_o;
    logic [CNT_W-1:0] arith_count_o;
    logic [CNT_W-1:0] mem_count_o;
    logic [CNT_W-1:0] cpi_o;
    logic             busy_o;
    logic             valid_o;

    modport master (
        output clear_i, start_i, halt_i, stall_i, arith_i, mem_i, retire_i,
        input  stall_count_o, arith_count_o, mem_count_o, cpi_o, busy_o, valid_o
    );

    modport slave (
        input  clear_i, start_i, halt_i, stall_i, arith_i, mem_i, retire_i,
        output stall_count_o, arith_count_o, mem_count_o, cpi_o, busy_o, valid_o
    );
endinterface

// File: rtl/perf_div.sv
// Restoring unsigned divider, one quotient bit per cycle over DVD_W cycles.
module perf_div #(
    parameter int unsigned DVD_W = 27,
    parameter int unsigned DVS_W = 19,
    parameter int unsigned OUT_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_c,
    output logic [OUT_W-1:0] quotient_o,
    output logic             ovf_c
);
    localparam int unsigned ITER_W = $clog2(DVD_W);
    localparam logic [ITER_W-1:0] LAST = ITER_W'(DVD_W - 1);

    logic [DVS_W-1:0]  rem_q, rem_d;
    logic [DVD_W-1:0]  quo_q, quo_d;
    logic [DVS_W-1:0]  dvs_q, dvs_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [DVS_W:0]    trial;

    // Dividend shifts out of quo_q MSB-first while quotient bits shift in at the LSB.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        trial  = {rem_q, quo_q[DVD_W-1]};
        done_c = busy_q && (cnt_q == LAST);
        if (abort_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            rem_d  = '0;
            quo_d  = dividend_i;
            dvs_d  = divisor_i;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (trial >= {1'b0, dvs_q}) begin
                rem_d = DVS_W'(trial - {1'b0, dvs_q});
                quo_d = {quo_q[DVD_W-2:0], 1'b1};
            end else begin
                rem_d = DVS_W'(trial);
                quo_d = {quo_q[DVD_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + ITER_W'(1);
            if (done_c) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign quotient_o = quo_q[OUT_W-1:0];
    assign ovf_c      = |quo_q[DVD_W-1:OUT_W];

endmodule

// File: rtl/perf_counters.sv
// Measurement-window event counters with a cycles-per-instruction result.
module perf_counters
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input logic           clkFPGA,
    input logic           rst,
    perf_counters_if.slave bus
);
    localparam int unsigned DVD_W = CNT_W + FRAC_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Assert asynchronously, release two edges after rst rises.
    logic rst_meta_q, rst_sync_q;
    always_ff @(posedge clkFPGA or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, inst_q, inst_d;
    logic [CNT_W-1:0] stall_q, stall_d, arith_q, arith_d, mem_q, mem_d, cpi_q, cpi_d;
    logic             busy_q, busy_d, valid_q, valid_d;
    logic             div_start_c, div_done_c, div_ovf_c, div_busy;
    logic [CNT_W-1:0] div_quot;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        inst_d      = inst_q;
        stall_d     = stall_q;
        arith_d     = arith_q;
        mem_d       = mem_q;
        cpi_d       = cpi_q;
        div_start_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d = ST_COUNT;
                    {cyc_d, inst_d, stall_d, arith_d, mem_d} = '0;
                end
            end
            ST_COUNT: begin
                cyc_d   = sat_inc(cyc_q, 1'b1);
                inst_d  = sat_inc(inst_q, bus.retire_i);
                stall_d = sat_inc(stall_q, bus.stall_i);
                arith_d = sat_inc(arith_q, bus.arith_i);
                mem_d   = sat_inc(mem_q, bus.mem_i);
                if (bus.halt_i) begin
                    state_d     = ST_DIVIDE;
                    div_start_c = (inst_d != '0);
                end
            end
            ST_DIVIDE: begin
                if ((inst_q == '0) || (div_busy && div_done_c)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // First DONE cycle latches the final quotient into the result.
                if (!valid_q) begin
                    cpi_d = ((inst_q == '0) || div_ovf_c) ? CNT_MAX : div_quot;
                end
                if (bus.start_i) begin
                    state_d = ST_COUNT;
                    {cyc_d, inst_d, stall_d, arith_d, mem_d} = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.clear_i) begin
            state_d     = ST_IDLE;
            div_start_c = 1'b0;
            {cyc_d, inst_d, stall_d, arith_d, mem_d, cpi_d} = '0;
        end
        busy_d  = (state_d == ST_COUNT) || (state_d == ST_DIVIDE);
        valid_d = (state_q == ST_DONE) && (state_d == ST_DONE);
    end

    always_ff @(posedge clkFPGA or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            inst_q  <= '0;
            stall_q <= '0;
            arith_q <= '0;
            mem_q   <= '0;
            cpi_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            inst_q  <= inst_d;
            stall_q <= stall_d;
            arith_q <= arith_d;
            mem_q   <= mem_d;
            cpi_q   <= cpi_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    perf_div #(
        .DVD_W(DVD_W),
        .DVS_W(CNT_W),
        .OUT_W(CNT_W)
    ) u_div (
        .clk       (clkFPGA),
        .rst_n     (rst_sync_q),
        .start_i   (div_start_c),
        .abort_i   (bus.clear_i),
        .dividend_i({cyc_d, FRAC_W'(0)}),
        .divisor_i (inst_d),
        .busy_o    (div_busy),
        .done_c    (div_done_c),
        .quotient_o(div_quot),
        .ovf_c     (div_ovf_c)
    );

    assign bus.stall_count_o = stall_q;
    assign bus.arith_count_o = arith_q;
    assign bus.mem_count_o   = mem_q;
    assign bus.cpi_o         = cpi_q;
    assign bus.busy_o        = busy_q;
    assign bus.valid_o       = valid_q;

endmodule

// File: tb/tb_perf_counters.sv
// Directed bench for perf_counters with a CPI/latency scoreboard.
module tb_perf_counters;
    localparam int unsigned CW  = 19;
    localparam int unsigned FW  = 8;
    localparam int unsigned SCW = 10;
    localparam int unsigned MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    perf_counters_if #(.CNT_W(CW))  bus ();
    perf_counters_if #(.CNT_W(SCW)) sbus ();

    perf_counters #(.CNT_W(CW), .FRAC_W(FW)) dut (
        .clkFPGA(clk), .rst(rst), .bus(bus)
    );
    perf_counters #(.CNT_W(SCW), .FRAC_W(FW)) dut_small (
        .clkFPGA(clk), .rst(rst), .bus(sbus)
    );

    typedef struct {
        logic [31:0] cpi;
        int          lat;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned m_cyc, m_inst, m_stall, m_arith, m_mem;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_cpi(input int unsigned cyc, input int unsigned inst,
                                              input int unsigned cw);
        longint unsigned mx, q;
        mx = (64'd1 << cw) - 64'd1;
        if (inst == 0) return 32'(mx);
        q = (longint'(cyc) << FW) / longint'(inst);
        return 32'((q > mx) ? mx : q);
    endfunction

    function automatic int unsigned sat(input int unsigned v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic clr_inputs();
        {bus.clear_i, bus.start_i, bus.halt_i, bus.stall_i, bus.arith_i, bus.mem_i, bus.retire_i} = '0;
        {sbus.clear_i, sbus.start_i, sbus.halt_i, sbus.stall_i, sbus.arith_i, sbus.mem_i, sbus.retire_i} = '0;
    endtask

    task automatic start_window(input logic with_halt);
        bus.start_i = 1'b1;
        bus.halt_i  = with_halt;
        tick();
        bus.start_i = 1'b0;
        bus.halt_i  = 1'b0;
        {m_cyc, m_inst, m_stall, m_arith, m_mem} = '0;
    endtask

    // One COUNT cycle; the model counts it, halt cycle included.
    task automatic cnt_cycle(input logic s, input logic a, input logic m, input logic r, input logic h);
        {bus.stall_i, bus.arith_i, bus.mem_i, bus.retire_i, bus.halt_i} = {s, a, m, r, h};
        m_cyc   = sat(m_cyc + 1);
        m_stall = sat(m_stall + 32'(s));
        m_arith = sat(m_arith + 32'(a));
        m_mem   = sat(m_mem + 32'(m));
        m_inst  = sat(m_inst + 32'(r));
        tick();
        {bus.stall_i, bus.arith_i, bus.mem_i, bus.retire_i, bus.halt_i} = '0;
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.cpi = model_cpi(m_cyc, m_inst, CW);
        e.lat = (m_inst == 0) ? 2 : int'(CW + FW + 1);
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic wait_result();
        int   n = 0;
        exp_t e;
        while (bus.valid_o !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (sb.size() == 0) begin
            check("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_valid"}, 32'(bus.valid_o), 32'd1);
            check({e.tag, "_latency"}, 32'(n), 32'(e.lat));
            check({e.tag, "_cpi"}, 32'(bus.cpi_o), e.cpi);
        end
    endtask

    initial begin
        int          seen;
        int          n;
        clr_inputs();
        repeat (2) tick();
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_cpi", 32'(bus.cpi_o), 32'd0);
        check("rst_counts", 32'(bus.stall_count_o | bus.arith_count_o | bus.mem_count_o), 32'd0);
        rst = 1'b1;
        repeat (3) tick();

        // Main window: 100 cycles, 50 retirements, 30/20/10 events.
        start_window(1'b0);
        check("w1_busy_count", 32'(bus.busy_o), 32'd1);
        for (int i = 0; i < 100; i++) begin
            cnt_cycle((i % 10) == 9, (i % 10) < 3, (i % 5) == 1, (i % 2) == 0, i == 99);
        end
        push_exp("w1");
        check("w1_stall", 32'(bus.stall_count_o), 32'(m_stall));
        check("w1_arith", 32'(bus.arith_count_o), 32'(m_arith));
        check("w1_mem", 32'(bus.mem_count_o), 32'(m_mem));
        check("w1_busy_div", 32'(bus.busy_o), 32'd1);
        wait_result();
        check("w1_cpi_const", 32'(bus.cpi_o), 32'h200);
        check("w1_busy_done", 32'(bus.busy_o), 32'd0);

        // Events and halt in DONE must not move anything.
        {bus.stall_i, bus.arith_i, bus.mem_i, bus.retire_i, bus.halt_i} = '1;
        repeat (3) tick();
        clr_inputs();
        tick();
        check("done_ign_stall", 32'(bus.stall_count_o), 32'd10);
        check("done_ign_arith", 32'(bus.arith_count_o), 32'd30);
        check("done_ign_valid", 32'(bus.valid_o), 32'd1);

        // New window from DONE with no retirements.
        start_window(1'b0);
        check("w2_cpi_hold", 32'(bus.cpi_o), 32'h200);
        check("w2_counts_zero", 32'(bus.stall_count_o | bus.arith_count_o | bus.mem_count_o), 32'd0);
        check("w2_valid_low", 32'(bus.valid_o), 32'd0);
        for (int i = 0; i < 5; i++) cnt_cycle(1'b0, 1'b0, 1'b0, 1'b0, i == 4);
        push_exp("w2_zero_inst");
        wait_result();

        // Clear in the 10th DIVIDE cycle discards the divide.
        start_window(1'b0);
        for (int i = 0; i < 8; i++) cnt_cycle(1'b1, 1'b1, 1'b1, 1'b1, i == 7);
        repeat (9) tick();
        check("clr_busy_pre", 32'(bus.busy_o), 32'd1);
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        check("clr_cpi", 32'(bus.cpi_o), 32'd0);
        check("clr_counts", 32'(bus.stall_count_o | bus.arith_count_o | bus.mem_count_o), 32'd0);
        check("clr_busy", 32'(bus.busy_o), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) seen++;
        end
        check("clr_stays_idle", 32'(seen), 32'd0);

        // start+halt together in IDLE: halt ignored, next-cycle halt counts one cycle.
        start_window(1'b1);
        check("sh_busy", 32'(bus.busy_o), 32'd1);
        cnt_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        push_exp("sh");
        wait_result();

        // Saturation on a narrow instance.
        sbus.start_i = 1'b1;
        tick();
        sbus.start_i = 1'b0;
        sbus.stall_i = 1'b1;
        repeat ((1 << SCW) + 4) tick();
        sbus.halt_i = 1'b1;
        tick();
        {sbus.halt_i, sbus.stall_i} = '0;
        check("sat_stall", 32'(sbus.stall_count_o), 32'((1 << SCW) - 1));
        check("sat_arith", 32'(sbus.arith_count_o), 32'd0);
        n = 0;
        while (sbus.valid_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("sat_latency", 32'(n), 32'd2);
        check("sat_cpi", 32'(sbus.cpi_o), model_cpi((1 << SCW) + 5, 0, SCW));

        // Asynchronous reset in the middle of COUNT.
        start_window(1'b0);
        for (int i = 0; i < 5; i++) cnt_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("arst_pre_stall", 32'(bus.stall_count_o), 32'(m_stall));
        #2;
        rst = 1'b0;
        #1;
        check("arst_counts", 32'(bus.stall_count_o | bus.arith_count_o | bus.mem_count_o), 32'd0);
        check("arst_busy", 32'(bus.busy_o), 32'd0);
        check("arst_valid", 32'(bus.valid_o), 32'd0);
        check("arst_small_cpi", 32'(sbus.cpi_o | 32'(sbus.valid_o)), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_counters.md
PERF_COUNTERS -- requirements
Module: perf_counters

Interface
REQ-001 Parameter CNT_W, default 19: width of every count and of the CPI result.
REQ-002 Parameter FRAC_W, default 8: fractional bits of the CPI result (unsigned fixed point).
REQ-003 clkFPGA  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 clear_i  input  1  synchronous clear of all counts and results.
REQ-006 start_i  input  1  begin a measurement window.
REQ-007 halt_i  input  1  program finished; close the window and compute CPI.
REQ-008 stall_i  input  1  pipeline stalled this cycle.
REQ-009 arith_i  input  1  arithmetic instruction retired this cycle.
REQ-010 mem_i  input  1  memory instruction retired this cycle.
REQ-011 retire_i  input  1  any instruction retired this cycle.
REQ-012 stall_count_o  output  CNT_W  stall cycles in window (R28 source).
REQ-013 arith_count_o  output  CNT_W  arithmetic retirements (R29 source).
REQ-014 mem_count_o  output  CNT_W  memory retirements (R30 source).
REQ-015 cpi_o  output  CNT_W  cycles per instruction, unsigned fixed point with FRAC_W fraction bits (R31 source).
REQ-016 busy_o  output  1  high in COUNT and DIVIDE.
REQ-017 valid_o  output  1  high in DONE; cpi_o is final.

Function
REQ-018 FSM states IDLE, COUNT, DIVIDE, DONE; reset state IDLE.
REQ-019 IDLE: start_i=1 -> COUNT on the next edge; counts and the internal cycle/instruction counters are zeroed on that edge.
REQ-020 COUNT: each cycle increments the internal cycle counter; each event input samples high -> its counter +1; retire_i drives the internal instruction counter.
REQ-021 COUNT: the cycle in which halt_i=1 is still counted, events included; the FSM -> DIVIDE on that edge and all counts freeze.
REQ-022 All counters saturate at 2^CNT_W-1; no wrap-around.
REQ-023 DIVIDE: restoring divide of (cycles << FRAC_W) by instructions, one quotient bit per cycle, CNT_W+FRAC_W cycles (27 at defaults); -> DONE on the final iteration edge.
REQ-024 Quotient exceeding CNT_W bits -> cpi_o = 2^CNT_W-1; instruction count 0 -> cpi_o = 2^CNT_W-1 without a divide, DONE entered the edge after DIVIDE entry.
REQ-025 DONE: outputs hold; start_i=1 -> COUNT (new window, counts zeroed, cpi_o holds until next DONE).
REQ-026 start_i outside IDLE/DONE and halt_i outside COUNT are ignored; event inputs outside COUNT are ignored.
REQ-027 clear_i has priority over every other input in every state: next edge all outputs 0, FSM -> IDLE, in-flight divide discarded.
REQ-028 Outputs are registered; no combinational path from any input to any output.

Reset
REQ-029 rst=0 asynchronously forces IDLE, all counts, cpi_o, busy_o and valid_o to 0, at any point including mid-COUNT or mid-DIVIDE.
REQ-030 Deassertion of rst is synchronised to clkFPGA before it affects the FSM.

Structure
REQ-031 Package perf_pkg holds CNT_W and FRAC_W defaults, the FSM state enum and the saturating-max constant.
REQ-032 The iterative divider is a separate sub-module perf_div (start/busy/done handshake, dividend, divisor, quotient, overflow flag).
REQ-033 perf_counters instantiates one perf_div and no other sub-modules.

Verification
REQ-034 Reset: rst=0 mid-COUNT with counts nonzero -> same cycle all outputs 0, busy_o=0, valid_o=0.
REQ-035 start, then 100 COUNT cycles with retire_i every 2nd cycle (50 instrs), arith_i on 30, mem_i on 20, stall_i on 10, halt_i on 100th -> counts 30/20/10, valid_o 28 edges after halt edge, cpi_o=0x00200 (2.0).
REQ-036 start, halt_i after 5 cycles with no retire_i -> cpi_o=0x7FFFF, valid_o 2 edges after halt edge.
REQ-037 stall_i held 2^19+5 COUNT cycles -> stall_count_o=524287, no wrap.
REQ-038 clear_i asserted in 10th DIVIDE cycle -> next edge all outputs 0, FSM IDLE, valid_o never rises.
REQ-039 start_i and halt_i both high in IDLE -> COUNT entered, halt ignored; halt_i next cycle -> cycle count 1 captured, cpi_o=0x7FFFF.
